// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the framed serial transmitter.
// The parity option is selected by the SERIAL_FRAME_TX_PARITY_EN macro in serial_frame_tx.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_GAP
  } state_t;

  // The far-end start-of-stream detector latches on the first 1 it sees,
  // so the start bit must be a 1 and the line must idle at 0.
  localparam logic START_LEVEL = 1'b1;

  // Bits in one frame: the start bit, the data bits and an optional parity bit.
  function automatic int frame_len(input int width, input int p);
    return 1 + width + p;
  endfunction

endpackage

// File: rtl/serial_frame_tx_piso_shift.sv
// Parallel-load, right-shift register.
// serial_out always shows the current LSB.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] shift_q;

  // A load takes priority over a shift. A shift moves the word toward the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      shift_q <= '0;
    else if (load)
      shift_q <= data_in;
    else if (shift)
      shift_q <= shift_q >> 1;
  end

  assign serial_out = shift_q[0];

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter.
// Each frame is a start bit of 1, then the data word LSB-first, then an optional
// even-parity bit, then GAP forced idle-0 cycles.
// Define SERIAL_FRAME_TX_PARITY_EN to include the parity bit.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | line at 0, ready_out=1, waiting for valid_in
// ST_START  | start bit (START_LEVEL) on the line
// ST_DATA   | data bits LSB-first, bit_cnt counts down to 0
// ST_PARITY | even parity of the latched word (parity builds only)
// ST_GAP    | forced idle 0, gap_cnt counts down, done in first cycle
//
// All registered outputs are computed from the next state. Each output therefore
// changes on the same edge as the state it belongs to.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP + 1);

  if (WIDTH < 1 || GAP < 1) begin : g_bad_param
    $error("serial_frame_tx: WIDTH and GAP must both be at least 1");
  end

  state_t          state, state_nxt;
  logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            load, shift_en, serial_bit, parity_bit;
  logic            tx_nxt, ready_nxt, done_nxt;

  piso_shift #(.WIDTH(WIDTH)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift      (shift_en),
    .data_in    (data_in),
    .serial_out (serial_bit)
  );

`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic parity_q;

  // Capture the even parity of the word when it is accepted. The shift register
  // no longer holds the whole word by the time the parity bit is sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      parity_q <= 1'b0;
    else if (load)
      parity_q <= ^data_in;
  end

  assign parity_bit = parity_q;
`else
  assign parity_bit = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

  // State, counters and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      tx_out    <= 1'b0;
      ready_out <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      tx_out    <= tx_nxt;
      ready_out <= ready_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic, the down-counters and the line value for the next state.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    load        = 1'b0;
    shift_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (valid_in && ready_out) begin
          state_nxt = ST_START;
          load      = 1'b1;
        end
      end
      ST_START: begin
        state_nxt   = ST_DATA;
        bit_cnt_nxt = BW'(WIDTH - 1);
        shift_en    = 1'b1;
      end
      ST_DATA: begin
        if (bit_cnt == '0) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
          state_nxt   = ST_PARITY;
`else
          state_nxt   = ST_GAP;
          gap_cnt_nxt = GW'(GAP - 1);
`endif
        end else begin
          bit_cnt_nxt = bit_cnt - BW'(1);
          shift_en    = 1'b1;
        end
      end
      ST_PARITY: begin
        state_nxt   = ST_GAP;
        gap_cnt_nxt = GW'(GAP - 1);
      end
      ST_GAP: begin
        if (gap_cnt == '0)
          state_nxt = ST_IDLE;
        else
          gap_cnt_nxt = gap_cnt - GW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The shift register is sampled before it shifts, so entering ST_DATA
    // puts the current LSB on the line.
    case (state_nxt)
      ST_START:  tx_nxt = START_LEVEL;
      ST_DATA:   tx_nxt = serial_bit;
      ST_PARITY: tx_nxt = parity_bit;
      default:   tx_nxt = 1'b0;
    endcase

    ready_nxt = (state_nxt == ST_IDLE);
    done_nxt  = (state_nxt == ST_GAP) && (state != ST_GAP);
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx (WIDTH=8, GAP=2) in the default or the parity build.
// Sample i of a frame is taken 1 time unit after the i-th clock edge that follows the accept edge.
module tb_serial_frame_tx;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PER = 2 + W + P + G;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         valid_in = 1'b0;
  logic         ready_out, tx_out, busy, done;

  int n_total = 0;
  int n_pass  = 0;

  serial_frame_tx #(.WIDTH(W), .GAP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Expected line trace of one frame: bit i is sample i.
  function automatic logic [63:0] exp_tx(input logic [7:0] d, input logic par);
    logic [63:0] r;
    r = '0;
    r[0] = 1'b1;
    for (int j = 0; j < W; j++) r[1+j] = d[j];
    if (P == 1) r[1+W] = par;
    return r;
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (ready_out !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (ready_out !== 1'b1) check("ready_timeout", {63'd0, ready_out}, 64'd1);
  endtask

  // Sends one word and records PER samples. data_in keeps changing after the accept edge.
  task automatic send_frame(input logic [7:0] d, output logic [63:0] tx_v,
                            output logic [63:0] dn_v, output logic [63:0] rd_v,
                            output logic [63:0] bs_v);
    tx_v = '0; dn_v = '0; rd_v = '0; bs_v = '0;
    wait_ready();
    data_in  = d;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int i = 0; i < PER; i++) begin
      tx_v[i] = tx_out;
      dn_v[i] = done;
      rd_v[i] = ready_out;
      bs_v[i] = busy;
      data_in = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  logic [63:0] tx_v, dn_v, rd_v, bs_v, lit;
  logic [63:0] exp_done, exp_ready, exp_busy;
  logic        acc_done, acc_tx;

  initial begin
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h01, 1'b1};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h00, 1'b0};
    vecs[6] = '{8'h3C, 1'b0};
    vecs[7] = '{8'hFE, 1'b1};

    exp_done  = 64'd1 << (1 + W + P);
    exp_ready = 64'd1 << (PER - 1);
    exp_busy  = (64'd1 << (PER - 1)) - 64'd1;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1 check("reset_outputs", {60'd0, tx_out, ready_out, busy, done}, 64'b0100);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // A5 against the hand-written trace. The parity bit is 0, so the literal also fits the parity build.
    lit = 64'b00101001011;
    send_frame(8'hA5, tx_v, dn_v, rd_v, bs_v);
    check("a5_trace", tx_v, lit);
    check("a5_done", dn_v, exp_done);
    check("a5_ready", rd_v, exp_ready);
    check("a5_busy", bs_v, exp_busy);

    // Table of words, with data_in scrambled while each frame is sent.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].data, tx_v, dn_v, rd_v, bs_v);
      check($sformatf("vec%0d_tx", v), tx_v, exp_tx(vecs[v].data, vecs[v].par));
      check($sformatf("vec%0d_done", v), dn_v, exp_done);
      check($sformatf("vec%0d_ready", v), rd_v, exp_ready);
      check($sformatf("vec%0d_busy", v), bs_v, exp_busy);
    end

    // Back-to-back: valid_in held high for 01 and then 80.
    wait_ready();
    tx_v = '0; dn_v = '0;
    data_in  = 8'h01;
    valid_in = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h80;
    for (int i = 0; i < 2 * PER + 3; i++) begin
      tx_v[i] = tx_out;
      dn_v[i] = done;
      if (i == PER) valid_in = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b_tx", tx_v, exp_tx(8'h01, 1'b1) | (exp_tx(8'h80, 1'b1) << PER));
    check("b2b_done", dn_v, exp_done | (exp_done << PER));

    // Reset while data bit 4 is on the line.
    wait_ready();
    data_in  = 8'h5F;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    check("mid_bit4_before_reset", {63'd0, tx_out}, 64'd1);
    #2 rst = 1'b1;
    #1 check("mid_reset_outputs", {60'd0, tx_out, ready_out, busy, done}, 64'b0100);
    @(negedge clk) rst = 1'b0;
    acc_done = 1'b0;
    acc_tx   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      acc_done |= done;
      acc_tx   |= tx_out;
    end
    check("mid_no_done", {62'd0, acc_done, acc_tx}, 64'd0);
    send_frame(8'h3C, tx_v, dn_v, rd_v, bs_v);
    check("post_reset_tx", tx_v, exp_tx(8'h3C, 1'b0));
    check("post_reset_done", dn_v, exp_done);
    check("post_reset_ready", rd_v, exp_ready);
    check("post_reset_busy", bs_v, exp_busy);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule
